// File: rtl/multi_qam_mapper_pkg.sv
// rtl/multi_qam_mapper_pkg.sv - shared types and helpers for the multi-mode QAM mapper
package mapper_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  // IQ word layout: I in the upper half, Q in the lower half
  localparam int IQ_W  = 16;
  localparam int I_LSB = 16;
  localparam int Q_LSB = 0;

  // First LUT entry of the table for a given bits-per-symbol
  function automatic logic [7:0] lut_base(input logic [2:0] b);
    return 8'd1 << b;
  endfunction

  function automatic logic [2:0] clamp_bps(input logic [2:0] b, input int max_bps);
    if (b == 3'd0) return 3'd1;
    if (int'(b) > max_bps) return 3'(max_bps);
    return b;
  endfunction

endpackage

// File: rtl/multi_qam_mapper_if.sv
// rtl/multi_qam_mapper_if.sv - payload-in and symbol-out stream bundle for the mapper
interface multi_qam_mapper_if #(
  parameter int IN_WIDTH  = 32,
  parameter int SYM_WIDTH = 32
);
  logic [IN_WIDTH-1:0]  t0_data;
  logic                 t0_last;
  logic                 t0_valid;
  logic                 t0_ready;
  logic [SYM_WIDTH-1:0] i_data;
  logic                 i_last;
  logic                 i_valid;
  logic                 i_ready;

  modport master (
    output t0_data, t0_last, t0_valid, i_ready,
    input  t0_ready, i_data, i_last, i_valid
  );

  modport slave (
    input  t0_data, t0_last, t0_valid, i_ready,
    output t0_ready, i_data, i_last, i_valid
  );
endinterface

// File: rtl/multi_qam_mapper_lut.sv
// rtl/multi_qam_mapper_lut.sv - constellation RAM with registered read into a 2-entry output queue
module mapper_lut #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] q_data [0:1];
  logic              q_last [0:1];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic              push, pop;

  // A slot frees up in the same cycle the head is taken downstream
  assign rd_ready  = (count != 2'd2) || out_ready;
  assign push      = rd_valid && rd_ready;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? q_data[rd_ptr] : '0;
  assign out_last  = out_valid && q_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (cfg_we) mem[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= mem[rd_addr];
      q_last[wr_ptr] <= rd_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/multi_qam_mapper.sv
// rtl/multi_qam_mapper.sv - unpacks payload words into 1..MAX_BPS-bit symbols and maps them via LUT
// MAPPER_SYM_CNT_EN: builds the per-packet sym_count counter; otherwise sym_count is tied to 0.
module multi_qam_mapper
  import mapper_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int SYM_WIDTH = 32,
  parameter int MAX_BPS   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           bps,
  input  logic                 cfg_we,
  input  logic [MAX_BPS:0]     cfg_addr,
  input  logic [SYM_WIDTH-1:0] cfg_data,
  output logic [15:0]          sym_count,
  multi_qam_mapper_if.slave    bus
);

  localparam int ADDR_W = MAX_BPS + 1;
  localparam int BUF_W  = IN_WIDTH + MAX_BPS - 1;
  localparam int CNT_W  = $clog2(BUF_W + 1);

  state_t             state, state_nx;
  logic [BUF_W-1:0]   bit_buf, bit_buf_nx, merged;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [2:0]         bps_l, bps_nx;
  logic               last_l, last_nx;
  logic               cnt_ge, space, emit, sym_last;
  logic [MAX_BPS-1:0] sym_src, sym_mask, sym;
  logic [ADDR_W-1:0]  lut_addr;
  logic [SYM_WIDTH-1:0] lut_dout;

  assign cnt_ge   = (cnt >= CNT_W'(bps_l));
  // Residual bits sit below cnt and everything above is zero, so OR-in is a safe append
  assign merged   = bit_buf | (BUF_W'(bus.t0_data) << cnt);
  assign sym_mask = MAX_BPS'((32'd1 << bps_l) - 32'd1);
  assign sym      = sym_src & sym_mask;
  assign lut_addr = ADDR_W'(lut_base(bps_l)) | ADDR_W'(sym);

  assign bus.t0_ready = !rst && ((state == IDLE) ||
                                 (state == RUN && !cnt_ge && !last_l && space));

  always_comb begin
    state_nx   = state;
    bit_buf_nx = bit_buf;
    cnt_nx     = cnt;
    bps_nx     = bps_l;
    last_nx    = last_l;
    emit       = 1'b0;
    sym_last   = 1'b0;
    sym_src    = bit_buf[MAX_BPS-1:0];
    case (state)
      IDLE: begin
        if (bus.t0_valid && bus.t0_ready) begin
          bit_buf_nx = BUF_W'(bus.t0_data);
          cnt_nx     = CNT_W'(IN_WIDTH);
          bps_nx     = clamp_bps(bps, MAX_BPS);
          last_nx    = bus.t0_last;
          state_nx   = RUN;
        end
      end
      RUN: begin
        if (cnt_ge) begin
          emit     = space;
          sym_last = last_l && (cnt == CNT_W'(bps_l));
          if (space) begin
            bit_buf_nx = bit_buf >> bps_l;
            cnt_nx     = cnt - CNT_W'(bps_l);
          end
        end else if (!last_l) begin
          // Straddling symbol: take the next word and emit in the same cycle
          if (bus.t0_valid && space) begin
            emit       = 1'b1;
            sym_src    = merged[MAX_BPS-1:0];
            bit_buf_nx = merged >> bps_l;
            cnt_nx     = cnt + CNT_W'(IN_WIDTH) - CNT_W'(bps_l);
            last_nx    = bus.t0_last;
          end
        end else if (cnt != '0) begin
          state_nx = FLUSH;
        end else begin
          state_nx = IDLE;
        end
      end
      FLUSH: begin
        emit     = space;
        sym_last = 1'b1;
        if (space) begin
          bit_buf_nx = '0;
          cnt_nx     = '0;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_buf <= '0;
      cnt     <= '0;
      bps_l   <= 3'd1;
      last_l  <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_buf <= bit_buf_nx;
      cnt     <= cnt_nx;
      bps_l   <= bps_nx;
      last_l  <= last_nx;
    end
  end

  mapper_lut #(
    .ADDR_W (ADDR_W),
    .DATA_W (SYM_WIDTH)
  ) u_lut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .rd_valid  (emit),
    .rd_ready  (space),
    .rd_addr   (lut_addr),
    .rd_last   (sym_last),
    .out_valid (bus.i_valid),
    .out_ready (bus.i_ready),
    .out_data  (lut_dout),
    .out_last  (bus.i_last)
  );

  assign bus.i_data = {lut_dout[I_LSB +: IQ_W], lut_dout[Q_LSB +: IQ_W]};

`ifdef MAPPER_SYM_CNT_EN
  logic clr_pending;
  logic out_hs;

  assign out_hs = bus.i_valid && bus.i_ready;

  // Final count stays visible for one cycle after the i_last handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_count   <= 16'd0;
      clr_pending <= 1'b0;
    end else begin
      clr_pending <= out_hs && bus.i_last;
      if (clr_pending)  sym_count <= out_hs ? 16'd1 : 16'd0;
      else if (out_hs)  sym_count <= sym_count + 16'd1;
    end
  end
`else
  assign sym_count = 16'd0;
`endif

endmodule

// File: doc/multi_qam_mapper.md
# multi_qam_mapper

Parametrised, runtime-selectable constellation mapper for the mapper/mover datapath. It accepts packed 32-bit payload words and unpacks them LSB-first into symbols of 1..MAX_BPS bits, carrying leftover bits across word boundaries. Each symbol is mapped through a programmable LUT holding all modes at once, and the block emits one 32-bit IQ word per symbol with packet framing. It replaces the fixed 8-QAM mapper and sits between the payload mover and the TX sample buffer.

## Interface
- `IN_WIDTH`, 32: payload word width.
- `SYM_WIDTH`, 32: output IQ word width (I in [31:16], Q in [15:0]).
- `MAX_BPS`, 6: largest bits-per-symbol supported. The LUT depth is 2^(MAX_BPS+1).
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `bps` in 3: bits per symbol. Sampled at the first word of each packet.
- `cfg_we` in 1: LUT write strobe.
- `cfg_addr` in MAX_BPS+1: LUT write address.
- `cfg_data` in SYM_WIDTH: LUT write data.
- `t0_data` in IN_WIDTH: payload word.
- `t0_last` in 1: last word of packet.
- `t0_valid` in 1, `t0_ready` out 1: input handshake.
- `i_data` out SYM_WIDTH: mapped symbol.
- `i_last` out 1: last symbol of packet.
- `i_valid` out 1, `i_ready` in 1: output handshake.
- `sym_count` out 16: symbols emitted in the current packet.

## Operation
- **Bit buffer:** IN_WIDTH+MAX_BPS-1 bits, plus a residual count `cnt`.
  - Symbol value = lowest `bps` bits of the buffer. The buffer shifts right by `bps` per emitted symbol.
- **bps clamping:** bps=0 is treated as 1; bps>MAX_BPS is treated as MAX_BPS.
  - The latched value is held for the whole packet. Changes to `bps` mid-packet are ignored.
- **LUT address:** (1<<bps) | symbol. Table for k bits occupies [2^k, 2^(k+1)-1]; address 0 is unused.
- **IDLE:**
  - `t0_ready`=1. On `t0_valid`: load the word, set cnt=IN_WIDTH, latch bps and t0_last, go to RUN.
- **RUN:**
  - If cnt≥bps: emit a symbol, cnt-=bps.
  - If cnt<bps, last not latched, and `t0_valid`: accept the word in the same cycle. The new word is placed above the residual bits, and the straddling symbol is emitted in that cycle. cnt = cnt+IN_WIDTH-bps. Throughput stays at full rate.
  - If cnt<bps and `t0_valid`=0: stall, no symbol.
  - If cnt<bps and last latched:
    - cnt>0: go to FLUSH.
    - cnt=0: the previous symbol was final; go to IDLE.
- **FLUSH:** emit one symbol from the residual bits, zero-padded in the MSBs, with `i_last`=1, then go to IDLE.
- **`i_last`:** asserted on the final symbol of the packet, either the FLUSH symbol or the exact-fit symbol when cnt reaches 0 with last latched.
- **Backpressure:** emission occurs only when the LUT stage can accept. Never drop or duplicate a symbol.
- **LUT writes:** accepted every cycle regardless of state. Writing a table that is in use mid-packet is undefined by design; software reprograms the LUT between packets only.

## Timing
- **LUT read:** registered, 1 cycle. Followed by a 2-entry elastic output buffer, so `i_ready` may be deasserted at any time.
- **Latency:** the word accepted in cycle N produces its first symbol on `i_valid` in cycle N+2.
- **Sustained rate:** 1 symbol/cycle while `i_ready`=1. A word takes ceil-or-floor(IN_WIDTH/bps) cycles depending on the residual.
- **`t0_ready`:** combinational from state, cnt and downstream space. It is high only in IDLE, or in RUN with cnt<bps, last not latched, and space available.
- **Reset:**
  - `t0_ready`=0, `i_valid`=0, `i_data`=0, `i_last`=0, `sym_count`=0.
  - State = IDLE one cycle after reset deasserts.
  - LUT contents are retained; no initialisation by reset.
- **Reset mid-packet:** residual bits and buffered symbols are discarded. No partial symbol appears after reset.
- **`sym_count`:** increments on each `i_valid && i_ready`. It clears on the cycle after the `i_last` handshake.

## Configuration
- `MAPPER_SYM_CNT_EN` defined: the `sym_count` counter is built as described.
- `MAPPER_SYM_CNT_EN` undefined: `sym_count` is tied to 0 and no counter logic is generated. Datapath behaviour is identical.

## Structure
- **Package `mapper_pkg`:**
  - State enum {IDLE, RUN, FLUSH}.
  - `lut_base(bps)` function.
  - Clamp function for bps.
  - IQ packing constants.
- **Sub-module `mapper_lut`:** simple dual-port RAM with a write port (cfg) and a registered read port with valid/ready, depth 2^(MAX_BPS+1).
  - It is reused by the output elastic buffer path.

## Test plan
- bps=3, LUT[a]=a, one word 0xFFFFFFFF with last → 11 symbols: 10× 15, then 11 with `i_last`; `sym_count`=11.
- bps=2, two words 0x000000E4, 0x0 (last) → 32 symbols; the first four are 4,5,6,7, the rest 4; `i_last` on the 32nd only.
- bps=6, continuous valid words, `i_ready`=1 → one symbol per cycle, no bubbles at word boundaries. The straddling symbol combines 2 residual bits with 4 new bits.
- `i_ready` toggled randomly, bps=5 → output sequence identical to the `i_ready`=1 run; no loss or duplication.
- bps=7 with MAX_BPS=6 → behaves as bps=6. bps=0 → behaves as bps=1.
- Assert `rst` mid-packet → `i_valid` low the next cycle. The next packet maps correctly from bit 0.
